add_sub: RTL and testbench
==========================

Name: add_sub

Overview:
- Registered WIDTH-bit two's-complement adder/subtractor.
- Select=0 computes A+B; Select=1 computes A−B, formed as A + ~B + 1.
- Datapath is a ripple-carry chain of full-adder cells followed by one output register stage.
- Used as a small arithmetic leaf inside larger datapaths.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- A  input  WIDTH  operand A (unsigned or two's complement).
- B  input  WIDTH  operand B.
- Select  input  1  operation: 0 = add, 1 = subtract.
- in_valid  input  1  qualifies A/B/Select this cycle.
- Sum  output  WIDTH  registered result, low WIDTH bits.
- Cout  output  1  registered carry out of the MSB cell.
- Ovf  output  1  registered signed-overflow flag.
- out_valid  output  1  registered; high one cycle after an accepted in_valid.

Behaviour:
- Reset: rst_n low asynchronously forces Sum=0, Cout=0, Ovf=0, out_valid=0. Release is synchronous to clk.
- Operand conditioning: each B bit is XORed with Select. The carry-in to bit 0 equals Select.
- Add (Select=0): {Cout,Sum} = A + B, computed exactly over WIDTH+1 bits.
- Subtract (Select=1): {Cout,Sum} = A + ~B + 1.
  - Cout=1 means no borrow (A ≥ B unsigned).
  - Cout=0 means borrow.
- Ovf = carry into MSB XOR carry out of MSB. This equals signed overflow for both operations.
- Latency: 1 cycle. On a rising clk with in_valid=1, Sum/Cout/Ovf load the combinational result and out_valid goes to 1.
- When in_valid=0 at a clk edge: Sum/Cout/Ovf hold their previous values and out_valid goes to 0.
- No back-pressure; a new operation is accepted every cycle.
- Wrap-around: results are modulo 2^WIDTH with no saturation. Examples: 1111+0001 → Sum=0000, Cout=1. 0000−0001 → Sum=1111, Cout=0.
- Select changes only take effect at a clk edge with in_valid=1. There are no combinational paths from inputs to outputs.
- Reset asserted mid-stream: outputs clear immediately. The first valid operand after release produces out_valid one cycle later.
- X on Select or operands while in_valid=0 must not affect the outputs.

Decomposition:
- Shared package add_sub_pkg holds:
  - DEFAULT_WIDTH = 4.
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
  - Nothing else.
- One sub-module, full_adder (a, b, cin → s, cout), instantiated WIDTH times in a generate loop.
- The carry chain vector has WIDTH+1 entries: entry 0 = Select, entry WIDTH = Cout.
- The output register and out_valid flop live in add_sub itself.

Test Plan:
- Reset: hold rst_n=0 with random inputs → Sum=0000, Cout=0, Ovf=0, out_valid=0.
  - Assert rst_n mid-stream → outputs clear without waiting for clk.
- Add (WIDTH=4, in_valid=1): each result appears one cycle later with out_valid=1.
  - 0000+0000 → 0000, Cout 0.
  - 1010+0101 → 1111, Cout 0.
  - 0101+1010 → 1111, Cout 0.
  - 1110+0001 → 1111, Cout 0.
- Subtract:
  - 1010−0101 → 0101, Cout 1, Ovf 1.
  - 0101−1010 → 1011, Cout 0, Ovf 1.
  - 1111−0001 → 1110, Cout 1, Ovf 0.
  - 0000−0001 → 1111, Cout 0, Ovf 0.
- Overflow and wrap:
  - 0111+0001 → 1000, Ovf 1, Cout 0.
  - 1111+0001 → 0000, Cout 1, Ovf 0.
  - 1000−0001 → 0111, Ovf 1, Cout 1.
- Valid handling: back-to-back in_valid for 8 cycles → 8 consecutive results in order.
  - in_valid=0 for one cycle with changed operands → out_valid=0 and Sum/Cout/Ovf unchanged.
- Random: 10k random A/B/Select for WIDTH=4 and WIDTH=8, compared against a reference model for {Cout,Sum} and Ovf at 1-cycle latency.

Source files
------------

// File: rtl/add_sub_pkg.sv
// Shared constants for the registered adder/subtractor.
package add_sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;
  localparam logic        OP_ADD        = 1'b0;
  localparam logic        OP_SUB        = 1'b1;

endpackage

// File: rtl/add_sub_full_adder.sv
// Single-bit full-adder cell used to build the ripple-carry chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/add_sub.sv
// Registered WIDTH-bit ripple-carry adder/subtractor with carry and signed-overflow flags.
module add_sub
  import add_sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Select,
  input  logic             in_valid,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             out_valid
);

  logic             sub;
  logic [WIDTH-1:0] b_cond;
  logic [WIDTH-1:0] sum_c;
  logic [WIDTH:0]   carry;

  // Subtraction is A + ~B + 1: invert B and inject the +1 as the chain carry-in.
  assign sub      = (Select == OP_SUB);
  assign b_cond   = B ^ {WIDTH{sub}};
  assign carry[0] = sub;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a   (A[i]),
      .b   (b_cond[i]),
      .cin (carry[i]),
      .s   (sum_c[i]),
      .cout(carry[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      Ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= sum_c;
        Cout <= carry[WIDTH];
        Ovf  <= carry[WIDTH] ^ carry[WIDTH-1];
      end
    end
  end

endmodule

// File: tb/tb_add_sub.sv
// Self-checking bench for add_sub at WIDTH=4 and WIDTH=8 using a per-cycle scoreboard.
module tb_add_sub;
  import add_sub_pkg::*;

  typedef struct {
    logic       v;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    int         due;
  } exp_t;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       sel;
    logic [3:0] sum;
    logic       cout;
    logic       ovf;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] a4, b4, sum4;
  logic [7:0] a8, b8, sum8;
  logic       sel4, v4, cout4, ovf4, ov4;
  logic       sel8, v8, cout8, ovf8, ov8;

  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t q4[$];
  exp_t q8[$];
  exp_t last4, last8;
  vec_t vecs[11];

  add_sub #(.WIDTH(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a4),
    .B        (b4),
    .Select   (sel4),
    .in_valid (v4),
    .Sum      (sum4),
    .Cout     (cout4),
    .Ovf      (ovf4),
    .out_valid(ov4)
  );

  add_sub #(.WIDTH(8)) u_dut8 (
    .clk      (clk),
    .rst_n    (rst_n),
    .A        (a8),
    .B        (b8),
    .Select   (sel8),
    .in_valid (v8),
    .Sum      (sum8),
    .Cout     (cout8),
    .Ovf      (ovf8),
    .out_valid(ov8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  // Reference: exact integer arithmetic, overflow judged on the true signed result.
  function automatic exp_t model(input int w, input logic [7:0] a, input logic [7:0] b,
                                 input logic sel, input logic v, input exp_t prev);
    exp_t        e;
    int unsigned mask, aa, bb;
    int          sa, sb, exact;
    e     = prev;
    e.v   = v;
    if (!v) return e;
    mask  = (32'd1 << w) - 1;
    aa    = 32'(a) & mask;
    bb    = 32'(b) & mask;
    sa    = ((aa >> (w - 1)) & 1) != 0 ? int'(aa) - (1 << w) : int'(aa);
    sb    = ((bb >> (w - 1)) & 1) != 0 ? int'(bb) - (1 << w) : int'(bb);
    if (sel == OP_SUB) begin
      e.sum  = 8'((aa - bb) & mask);
      e.cout = (aa >= bb);
      exact  = sa - sb;
    end else begin
      e.sum  = 8'((aa + bb) & mask);
      e.cout = (((aa + bb) >> w) & 1) != 0;
      exact  = sa + sb;
    end
    e.ovf = (exact > (1 << (w - 1)) - 1) || (exact < -(1 << (w - 1)));
    return e;
  endfunction

  function automatic void compare(input string name, input exp_t e, input logic v,
                                  input logic [7:0] sum, input logic cout, input logic ovf);
    checks++;
    if (v !== e.v || sum !== e.sum || cout !== e.cout || ovf !== e.ovf) begin
      errors++;
      $display("FAIL %s @%0t: got v=%b sum=%h cout=%b ovf=%b, want v=%b sum=%h cout=%b ovf=%b",
               name, $time, v, sum, cout, ovf, e.v, e.sum, e.cout, e.ovf);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [3:0] a, input logic [3:0] b, input logic s,
                        input logic v, input exp_t e);
    a4 = a; b4 = b; sel4 = s; v4 = v;
    e.due = cycle + 1;
    q4.push_back(e);
    last4 = e;
  endtask

  task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic s,
                        input logic v, input exp_t e);
    a8 = a; b8 = b; sel8 = s; v8 = v;
    e.due = cycle + 1;
    q8.push_back(e);
    last8 = e;
  endtask

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s, input logic v);
    drive4(a, b, s, v, model(4, {4'b0, a}, {4'b0, b}, s, v, last4));
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input logic v);
    drive8(a, b, s, v, model(8, a, b, s, v, last8));
  endtask

  task automatic check_zero(input string name);
    exp_t z;
    z = '{v: 1'b0, sum: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
    compare({name, "_w4"}, z, ov4, {4'b0, sum4}, cout4, ovf4);
    compare({name, "_w8"}, z, ov8, sum8, cout8, ovf8);
  endtask

  // Scoreboard pop: each entry is due the cycle after it was driven.
  always @(negedge clk) begin
    if (rst_n) begin
      if (q4.size() > 0 && q4[0].due <= cycle) compare("w4", q4.pop_front(), ov4, {4'b0, sum4},
                                                      cout4, ovf4);
      if (q8.size() > 0 && q8[0].due <= cycle) compare("w8", q8.pop_front(), ov8, sum8, cout8,
                                                      ovf8);
    end
  end

  initial begin
    exp_t e;
    vecs[0]  = '{4'b0000, 4'b0000, OP_ADD, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b1010, 4'b0101, OP_ADD, 4'b1111, 1'b0, 1'b0};
    vecs[2]  = '{4'b0101, 4'b1010, OP_ADD, 4'b1111, 1'b0, 1'b0};
    vecs[3]  = '{4'b1110, 4'b0001, OP_ADD, 4'b1111, 1'b0, 1'b0};
    vecs[4]  = '{4'b1010, 4'b0101, OP_SUB, 4'b0101, 1'b1, 1'b1};
    vecs[5]  = '{4'b0101, 4'b1010, OP_SUB, 4'b1011, 1'b0, 1'b1};
    vecs[6]  = '{4'b1111, 4'b0001, OP_SUB, 4'b1110, 1'b1, 1'b0};
    vecs[7]  = '{4'b0000, 4'b0001, OP_SUB, 4'b1111, 1'b0, 1'b0};
    vecs[8]  = '{4'b0111, 4'b0001, OP_ADD, 4'b1000, 1'b0, 1'b1};
    vecs[9]  = '{4'b1111, 4'b0001, OP_ADD, 4'b0000, 1'b1, 1'b0};
    vecs[10] = '{4'b1000, 4'b0001, OP_SUB, 4'b0111, 1'b1, 1'b1};

    last4 = '{v: 1'b0, sum: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
    last8 = last4;
    a4 = '0; b4 = '0; sel4 = 1'b0; v4 = 1'b0;
    a8 = '0; b8 = '0; sel8 = 1'b0; v8 = 1'b0;

    // Reset held with random stimulus, including in_valid pulses.
    #1 rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      a4 = 4'($urandom); b4 = 4'($urandom); sel4 = 1'($urandom); v4 = 1'b1;
      a8 = 8'($urandom); b8 = 8'($urandom); sel8 = 1'($urandom); v8 = 1'b1;
      @(negedge clk);
      check_zero("reset_hold");
    end
    v4 = 1'b0; v8 = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on the 4-bit instance.
    for (int i = 0; i < 11; i++) begin
      tick();
      e = '{v: 1'b1, sum: {4'b0, vecs[i].sum}, cout: vecs[i].cout, ovf: vecs[i].ovf, due: 0};
      drive4(vecs[i].a, vecs[i].b, vecs[i].sel, 1'b1, e);
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // Idle cycle with changed operands: flags drop, data holds.
    tick();
    op4(4'b0110, 4'b0011, OP_SUB, 1'b0);
    op8(8'h7f, 8'h01, OP_ADD, 1'b0);

    // Eight back-to-back operations.
    for (int i = 0; i < 8; i++) begin
      tick();
      op4(4'($urandom), 4'($urandom), 1'($urandom), 1'b1);
      op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b1);
    end

    // Mid-stream reset: load a non-zero result, then clear between clock edges.
    tick();
    op4(4'b0111, 4'b0001, OP_ADD, 1'b1);
    op8(8'h7f, 8'h01, OP_ADD, 1'b1);
    tick();
    v4 = 1'b1; v8 = 1'b1;
    #2;
    q4.delete();
    q8.delete();
    rst_n = 1'b0;
    #1;
    check_zero("reset_async");
    last4 = '{v: 1'b0, sum: 8'h0, cout: 1'b0, ovf: 1'b0, due: 0};
    last8 = last4;
    @(negedge clk);
    check_zero("reset_mid_hold");
    rst_n = 1'b1;
    tick();
    op4(4'b1111, 4'b0001, OP_ADD, 1'b1);
    op8(8'h80, 8'h01, OP_SUB, 1'b1);

    // Random operations with sporadic idle cycles.
    for (int i = 0; i < 10000; i++) begin
      tick();
      op4(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0));
      op8(8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 9) != 0));
    end

    tick();
    op4(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
    op8(8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 5 && (q4.size() > 0 || q8.size() > 0); i++) @(negedge clk);
    #1;
    checks++;
    if (q4.size() > 0 || q8.size() > 0) begin
      errors++;
      $display("FAIL drain: got %0d/%0d pending, want 0/0", q4.size(), q8.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
